// File: rtl/serial_adder_acc.sv
// serial_adder_acc: chunked-I/O bit-serial add/sub/accumulate unit with valid/ready ports
module serial_adder_acc #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CHUNK-1:0] in_data,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             carry_out,
  output logic             busy
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(NCH - 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [1:0] SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, CALC, EMIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a, b, r, acc;
  logic [1:0] op_q, op_cur;
  logic c, c_nx, s, bx, in_fire, out_fire, last_beat, clr;
  always_comb begin
    in_ready = state == LOAD_A || state == LOAD_B;
    out_valid = state == EMIT;
    in_fire = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    last_beat = cnt == BEAT_LAST;
    busy = !(state == LOAD_A && cnt == '0);
    out_data = out_valid ? r[CHUNK-1:0] : '0;
    op_cur = cnt == '0 ? op : op_q;
    clr = state == LOAD_A && in_fire && cnt == '0 && op == CLR;
    bx = b[0] ^ (op_q == SUB);
    s = a[0] ^ bx ^ c;
    c_nx = (a[0] & bx) | ((a[0] ^ bx) & c);
    state_nx = state;
    case (state)
      LOAD_A: if (in_fire && !clr && last_beat) state_nx = op_cur == ACC ? CALC : LOAD_B;
      LOAD_B: if (in_fire && last_beat) state_nx = CALC;
      CALC:   if (cnt == BIT_LAST) state_nx = EMIT;
      EMIT:   if (out_fire && last_beat) state_nx = LOAD_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD_A;
      cnt <= '0;
      acc <= '0;
      a <= '0;
      b <= '0;
      r <= '0;
      c <= 1'b0;
      op_q <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD_A: if (in_fire) begin
          if (cnt == '0) op_q <= op;
          if (clr) acc <= '0;
          else begin
            a <= (a >> CHUNK) | (WIDTH'(in_data) << (WIDTH - CHUNK));
            cnt <= last_beat ? '0 : cnt + CW'(1);
            c <= 1'b0;
            if (last_beat && op_cur == ACC) b <= acc;
          end
        end
        LOAD_B: if (in_fire) begin
          b <= (b >> CHUNK) | (WIDTH'(in_data) << (WIDTH - CHUNK));
          cnt <= last_beat ? '0 : cnt + CW'(1);
          c <= op_q == SUB;
        end
        CALC: begin
          a <= a >> 1;
          b <= b >> 1;
          c <= c_nx;
          r <= {s, r[WIDTH-1:1]};
          cnt <= cnt == BIT_LAST ? '0 : cnt + CW'(1);
          if (cnt == BIT_LAST) begin
            carry_out <= c_nx;
            if (op_q == ACC) acc <= {s, r[WIDTH-1:1]};
          end
        end
        EMIT: if (out_fire) begin
          r <= r >> CHUNK;
          cnt <= last_beat ? '0 : cnt + CW'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_acc.sv
// tb_serial_adder_acc: directed vectors for serial_adder_acc at WIDTH=8, CHUNK=4
module tb_serial_adder_acc;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, carry_out, busy;
  logic [3:0] in_data = '0, out_data;
  logic [1:0] op = '0;
  int passes = 0, total = 0;
  always #5 clk = ~clk;
  serial_adder_acc #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .carry_out(carry_out), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic beat(input logic [3:0] d, input logic [1:0] o);
    in_valid = 1;
    in_data = d;
    op = o;
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic run(input string tag, input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] r, input logic c, input bit stall);
    int n = 0;
    logic [3:0] d;
    logic cs;
    beat(a[3:0], o);
    beat(a[7:4], ~o);
    if (o != 2'b10) begin
      beat(b[3:0], ~o);
      beat(b[7:4], ~o);
    end
    check({tag, ".calc_ready"}, 32'(in_ready), 0);
    check({tag, ".calc_busy"}, 32'(busy), 1);
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, ".latency"}, 32'(n + 1), 9);
    check({tag, ".carry"}, 32'(carry_out), 32'(c));
    if (stall) begin
      d = out_data;
      cs = carry_out;
      in_valid = 1;
      in_data = 4'hF;
      repeat (5) begin
        @(posedge clk);
        #1;
        check({tag, ".stall_data"}, 32'(out_data), 32'(d));
        check({tag, ".stall_carry"}, 32'(carry_out), 32'(cs));
        check({tag, ".stall_ready"}, 32'(in_ready), 0);
        check({tag, ".stall_valid"}, 32'(out_valid), 1);
      end
      in_valid = 0;
    end
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.valid%0d", tag, i), 32'(out_valid), 1);
      check($sformatf("%s.beat%0d", tag, i), 32'(out_data), 32'(r[4*i +: 4]));
      @(posedge clk);
      #1;
    end
    out_ready = 0;
    check({tag, ".done_valid"}, 32'(out_valid), 0);
    check({tag, ".done_ready"}, 32'(in_ready), 1);
    check({tag, ".carry_hold"}, 32'(carry_out), 32'(c));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.out_data", 32'(out_data), 0);
    check("rst.carry", 32'(carry_out), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.in_ready", 32'(in_ready), 1);
    reset = 0;
    run("t1_add", 2'b00, 8'h5A, 8'h3C, 8'h96, 1'b0, 0);
    run("t2_add_wrap", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 0);
    run("t3_sub", 2'b01, 8'h10, 8'h01, 8'h0F, 1'b1, 0);
    run("t3_sub_borrow", 2'b01, 8'h01, 8'h02, 8'hFF, 1'b0, 0);
    beat(4'h7, 2'b11);
    check("t4_clr.busy", 32'(busy), 0);
    check("t4_clr.out_valid", 32'(out_valid), 0);
    check("t4_clr.in_ready", 32'(in_ready), 1);
    run("t4_acc1", 2'b10, 8'h80, 8'h00, 8'h80, 1'b0, 0);
    run("t4_acc2", 2'b10, 8'h90, 8'h00, 8'h10, 1'b1, 0);
    run("t5_stall", 2'b00, 8'h12, 8'h34, 8'h46, 1'b0, 1);
    beat(4'h1, 2'b00);
    beat(4'h1, 2'b11);
    beat(4'h2, 2'b11);
    beat(4'h2, 2'b11);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    check("t6_rst.out_valid", 32'(out_valid), 0);
    check("t6_rst.in_ready", 32'(in_ready), 1);
    check("t6_rst.busy", 32'(busy), 0);
    run("t6_acc", 2'b10, 8'h01, 8'h00, 8'h01, 1'b0, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
